// File: rtl/ram_bist.sv
// Built-in self-test initiator for the dual-port synchronous RAM: writes pattern(a), reads it back, counts mismatches.
// Optional inverted second pass (~pattern(a)) is enabled by defining RAM_BIST_INV_PASS_EN.
module ram_bist #(
    parameter int                ADDR_W   = 5,
    parameter int                DEPTH    = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PAT_SEED = {DATA_W/8{8'hA5}}
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [15:0]       o_err_cnt,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data
);

`ifdef RAM_BIST_INV_PASS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_INV_WRITE, S_INV_READ, S_INV_DRAIN, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_t;
`endif

    // Terminal count is compared on the widened counter so DEPTH = 2^ADDR_W never wraps.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ PAT_SEED;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W:0]     addr_q, addr_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic                wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0]   exp_word;
`ifdef RAM_BIST_INV_PASS_EN
    logic                cmp_inv_q, cmp_inv_d;
`endif

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            wr_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_q        <= 1'b0;
            rd_addr_q   <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            cmp_inv_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            wr_q        <= wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_q        <= rd_d;
            rd_addr_q   <= rd_addr_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
`ifdef RAM_BIST_INV_PASS_EN
            cmp_inv_q   <= cmp_inv_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        wr_d        = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_d        = 1'b0;
        rd_addr_d   = rd_addr_q;
        // The read issued this cycle returns data next cycle, so its address rides one stage behind.
        cmp_vld_d   = rd_q;
        cmp_addr_d  = rd_addr_q;
        exp_word    = pattern(cmp_addr_q);
`ifdef RAM_BIST_INV_PASS_EN
        cmp_inv_d   = (state_q == S_INV_READ);
        if (cmp_inv_q) exp_word = ~pattern(cmp_addr_q);
`endif

        if (cmp_vld_q && (i_rd_data != exp_word)) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (err_cnt_q == 16'd0) fail_addr_d = cmp_addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d     = S_WRITE;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    wr_d        = 1'b1;
                    wr_addr_d   = '0;
                    wr_data_d   = pattern('0);
                end
            end
            S_WRITE: begin
                if (addr_q == LAST) begin
                    state_d   = S_READ;
                    addr_d    = '0;
                    rd_d      = 1'b1;
                    rd_addr_d = '0;
                end else begin
                    addr_d    = addr_q + 1'b1;
                    wr_d      = 1'b1;
                    wr_addr_d = addr_d[ADDR_W-1:0];
                    wr_data_d = pattern(addr_d[ADDR_W-1:0]);
                end
            end
            S_READ: begin
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d    = addr_q + 1'b1;
                    rd_d      = 1'b1;
                    rd_addr_d = addr_d[ADDR_W-1:0];
                end
            end
`ifdef RAM_BIST_INV_PASS_EN
            S_DRAIN: begin
                state_d   = S_INV_WRITE;
                addr_d    = '0;
                wr_d      = 1'b1;
                wr_addr_d = '0;
                wr_data_d = ~pattern('0);
            end
            S_INV_WRITE: begin
                if (addr_q == LAST) begin
                    state_d   = S_INV_READ;
                    addr_d    = '0;
                    rd_d      = 1'b1;
                    rd_addr_d = '0;
                end else begin
                    addr_d    = addr_q + 1'b1;
                    wr_d      = 1'b1;
                    wr_addr_d = addr_d[ADDR_W-1:0];
                    wr_data_d = ~pattern(addr_d[ADDR_W-1:0]);
                end
            end
            S_INV_READ: begin
                if (addr_q == LAST) begin
                    state_d = S_INV_DRAIN;
                end else begin
                    addr_d    = addr_q + 1'b1;
                    rd_d      = 1'b1;
                    rd_addr_d = addr_d[ADDR_W-1:0];
                end
            end
            S_INV_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == 16'd0);
            end
`else
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == 16'd0);
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_fail_addr = fail_addr_q;
    assign o_wr        = wr_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_rd        = rd_q;
    assign o_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: RAM model with injectable read corruption / stuck bits, table of runs, write/read scoreboard.
module tb_ram_bist;

`ifdef RAM_BIST_INV_PASS_EN
    localparam int PASSES    = 2;
    localparam int DONE_EDGE = 130;
`else
    localparam int PASSES    = 1;
    localparam int DONE_EDGE = 65;
`endif
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass, wr, rd;
    logic [15:0] err_cnt;
    logic [4:0]  fail_addr, wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;

    ram_bist dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
        .o_fail_addr(fail_addr), .o_wr(wr), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_rd(rd), .o_rd_addr(rd_addr), .i_rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] flip_mask;
        logic [31:0] stuck_mask;
        logic        exp_pass;
        int          exp_err;
        int          exp_fail;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wexp_t;

    vec_t        vecs[5];
    wexp_t       wq[$];
    int          rq[$];
    logic [31:0] mem[DEPTH];
    logic [31:0] flip_mask = '0;
    logic [31:0] stuck_mask = '0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    function automatic logic [31:0] pat(input int a, input bit inv);
        logic [31:0] p;
        p = 32'(a) ^ 32'hA5A5A5A5;
        return inv ? ~p : p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: bit 0 stuck at 1 on masked addresses, bit 3 flipped on masked readbacks
    always @(posedge clk) begin
        if (wr) mem[wr_addr] <= wr_data | {31'd0, stuck_mask[wr_addr]};
        if (rd) rd_data <= mem[rd_addr] ^ (flip_mask[rd_addr] ? 32'h8 : 32'h0);
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr) begin
            wr_cnt++;
            if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                wexp_t e;
                e = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
        if (rd) begin
            rd_cnt++;
            if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else chk("rd_addr", 32'(rd_addr), 32'(rq.pop_front()));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_wr"}, 32'(wr), 0);
        chk({tag, "_rd"}, 32'(rd), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_fail_addr"}, 32'(fail_addr), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    task automatic run(input int vi, input int extra, input bit rst_mid, input bit b2b);
        int e;
        int got;
        flip_mask  = vecs[vi].flip_mask;
        stuck_mask = vecs[vi].stuck_mask;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < DEPTH; a++) wq.push_back('{a, pat(a, p == 1)});
            for (int a = 0; a < DEPTH; a++) rq.push_back(a);
        end
        done_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        e = 0;
        got = -1;
        while (e < 400 && got < 0) begin
            @(posedge clk); e++; #1;
            if (e == extra - 1) start = 1'b1;
            if (e == extra) start = 1'b0;
            if (rst_mid && e == 19) rst_n = 1'b0;
            if (rst_mid && e == 20) begin
                chk_all_zero("midrst");
                rst_n = 1'b1;
                wq.delete();
                rq.delete();
                return;
            end
            if (done) got = e;
        end
        chk("done_edge", 32'(got), 32'(DONE_EDGE));
        chk("pass", 32'(pass), 32'(vecs[vi].exp_pass));
        chk("err_cnt", 32'(err_cnt), 32'(vecs[vi].exp_err));
        chk("fail_addr", 32'(fail_addr), 32'(vecs[vi].exp_fail));
        if (b2b) start = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("pass_held", 32'(pass), 32'(vecs[vi].exp_pass));
        if (b2b) begin
            wq.push_back('{0, pat(0, 1'b0)});
            @(posedge clk); #1;
            chk("b2b_busy", 32'(busy), 1);
            chk("b2b_wr", 32'(wr), 1);
            start = 1'b0;
            rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
        end else begin
            repeat (2) @(posedge clk);
            #1;
        end
        chk("done_pulses", 32'(done_cnt), 1);
        chk("wr_count", 32'(wr_cnt), 32'(DEPTH * PASSES + (b2b ? 1 : 0)));
        chk("rd_count", 32'(rd_cnt), 32'(DEPTH * PASSES));
        chk("wq_empty", 32'(wq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
    endtask

    initial begin
        vecs[0] = '{32'h0, 32'h0, 1'b1, 0, 0};
        vecs[1] = '{32'h0000_0020, 32'h0, 1'b0, 1 * PASSES, 5};
        vecs[2] = '{32'h8000_0204, 32'h0, 1'b0, 3 * PASSES, 2};
`ifdef RAM_BIST_INV_PASS_EN
        vecs[3] = '{32'h0, 32'h0000_0010, 1'b0, 1, 4};
`else
        vecs[3] = '{32'h0, 32'h0000_0010, 1'b1, 0, 0};
`endif
        vecs[4] = '{32'h8000_0001, 32'h0, 1'b0, 2 * PASSES, 0};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run(i, -1, 1'b0, 1'b0);
        run(0, 10, 1'b0, 1'b0);
        run(1, -1, 1'b1, 1'b0);
        run(0, -1, 1'b0, 1'b0);
        run(0, -1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test initiator for the team's dual-port synchronous RAM. It drives the RAM's write and read ports, writes a deterministic address-derived pattern to every word, then reads each word back and compares it with the expected value. It reports pass/fail, a mismatch count and the first failing address. It sits beside the RAM and is muxed onto the RAM ports only during test.

## Interface
- ADDR_W, 5, RAM address width
- DEPTH, 32, number of words tested (addresses 0..DEPTH-1); DEPTH ≤ 2^ADDR_W
- DATA_W, 32, RAM data width
- PAT_SEED, {DATA_W/8{8'hA5}}, DATA_W-bit XOR seed for the pattern

Ports:
- i_sys_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  start request; sampled only in IDLE
- o_busy  out  1  high from the cycle after start acceptance until o_done
- o_done  out  1  one-cycle pulse when the test completes
- o_pass  out  1  result, valid from o_done until the next accepted start
- o_err_cnt  out  16  mismatch count, saturates at 16'hFFFF
- o_fail_addr  out  ADDR_W  address of the first mismatch; 0 if none
- o_wr  out  1  RAM write enable
- o_wr_addr  out  ADDR_W  RAM write address
- o_wr_data  out  DATA_W  RAM write data
- o_rd  out  1  RAM read enable
- o_rd_addr  out  ADDR_W  RAM read address
- i_rd_data  in  DATA_W  RAM registered read data; valid one cycle after o_rd

## Operation
- pattern(a) = zero_extend(a) XOR PAT_SEED, DATA_W bits. The inverted pass uses ~pattern(a).
- FSM states: IDLE → WRITE → READ → DRAIN → (INV_WRITE → INV_READ → INV_DRAIN, only with the macro) → DONE → IDLE.
- IDLE: all RAM strobes low. If i_start=1, clear o_err_cnt, o_fail_addr and o_pass, then go to WRITE with addr=0.
- WRITE: o_wr=1, o_wr_addr=addr, o_wr_data=pattern(addr). addr increments each cycle. After DEPTH-1 the FSM goes to READ and addr resets to 0.
- READ: o_rd=1, o_rd_addr=addr. A one-cycle pipeline register holds cmp_valid and the expected address. After address DEPTH-1 the FSM goes to DRAIN.
- Compare: in the cycle when cmp_valid=1, i_rd_data is compared with the expected word. On mismatch:
  - o_err_cnt increments, saturating.
  - If this is the first error, o_fail_addr takes the expected address.
- DRAIN: one cycle, no strobes, completes the last compare.
- DONE: o_done=1 and o_busy=0 for one cycle, then IDLE. o_pass = (o_err_cnt==0) is registered on entry to DONE and held.
- i_start while busy: ignored, no effect.
- Address counter: ADDR_W+1 bits internally. The terminal compare is against DEPTH-1, so there is no wrap when DEPTH = 2^ADDR_W.
- Reset (at any time, including mid-run):
  - State returns to IDLE.
  - o_busy, o_done, o_pass, o_wr and o_rd are 0.
  - o_err_cnt, o_fail_addr, both addresses and o_wr_data are 0.
  - The pipeline register is cleared, so no stale compare occurs after reset.

## Timing
- All outputs are registered.
- Edge 0 samples i_start=1. o_busy=1 after edge 0.
- Writes: o_wr=1 in the cycles after edges 0..DEPTH-1; address k is written at edge k+1.
- Reads: o_rd=1 in the cycles after edges DEPTH..2·DEPTH-1. Address j is read at edge DEPTH+1+j and compared at edge DEPTH+2+j.
- The last compare lands at edge 2·DEPTH+1 (DRAIN). o_done=1 and o_pass are valid in the cycle after edge 2·DEPTH+1.
- For DEPTH=32, o_done is high in the cycle after edge 65.
- With the macro defined, the inverted pass follows directly. o_done is then high after edge 4·DEPTH+2 (edge 130 for DEPTH=32).
- Back-to-back runs: i_start held high during the DONE cycle is not accepted. It is accepted on the first IDLE cycle.

## Configuration
- RAM_BIST_INV_PASS_EN
  - Defined: after DRAIN, a second full write/read/drain pass runs with ~pattern(a). Errors from both passes accumulate in o_err_cnt, and o_fail_addr keeps the first error of the whole run.
  - Undefined: a single pass only; the INV_* states and the inversion logic are not present.

## Test plan
- Fault-free RAM, DEPTH=32, macro off, start pulse at edge 0 → o_done after edge 65, o_pass=1, o_err_cnt=0, o_fail_addr=0, 32 writes and 32 reads observed.
- RAM model corrupts the readback of addr 5 (bit 3 flipped) → o_pass=0, o_err_cnt=1, o_fail_addr=5.
- Corruptions at addrs 9, 2 and 31 → o_err_cnt=3, o_fail_addr=2 (first one read in address order).
- i_start pulsed again at edge 10 of a run → ignored; o_done still after edge 65, exactly one o_done pulse.
- i_rst_n low at edge 20 mid-run → all outputs 0 next cycle. A new start then gives a clean pass with o_done after edge 65 relative to that start.
- Macro on, bit 0 of addr 4 stuck at 1 (pattern(4)=32'hA5A5A5A1) → first pass clean, inverted pass fails. o_done after edge 130, o_err_cnt=1, o_fail_addr=4, o_pass=0.
